// File: rtl/imem_loader_arbiter_pkg.sv
// Shared types and constants for the instruction-memory loader.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_RUN,
    ST_OVERFLOW
  } loader_state_t;

  localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD = 4;
  localparam int          WORD_STRIDE    = 4;

endpackage

// File: rtl/imem_loader_arbiter_byte_word_assembler.sv
// Packs a byte stream into words, first byte ending up in the MSB.
module byte_word_assembler
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic         i_rx_valid,
  input  logic [7:0]   i_rx_data,
  output logic         o_word_ready,
  output logic [W-1:0] o_word
);

  logic [W-1:0] shreg;
  logic [1:0]   byte_cnt;
  logic         take;

  // A clear in the same cycle as a strobe discards that byte.
  assign take         = i_enable && i_rx_valid && !i_clear;
  assign o_word_ready = take && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word       = {shreg[W-9:0], i_rx_data};

  // Shift register and byte counter; counter wraps to 0 on the last byte.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (i_clear) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (take) begin
      shreg    <= o_word;
      byte_cnt <= o_word_ready ? 2'd0 : byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader_arbiter.sv
// Loads program memory from a byte stream, then hands the port to fetch.
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_IDLE     | after reset; CPU off, port follows i_PC
// ST_RECV     | assembling bytes into the next word
// ST_WRITE    | one-cycle write of the assembled word
// ST_RUN      | HALT stored; CPU enabled, port follows i_PC
// ST_OVERFLOW | load ran past memory end; sticky error
module imem_loader_arbiter
  import mips_pkg::*;
#(
  parameter int               NBITS     = 32,
  parameter int               CELDAS    = 64,
  parameter logic [NBITS-1:0] HALT_WORD = mips_pkg::HALT_WORD
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_valid,
  input  logic                      i_start_load,
  input  logic [NBITS-1:0]          i_PC,
  output logic [NBITS-1:0]          o_mem_addr,
  output logic [NBITS-1:0]          o_mem_wdata,
  output logic                      o_mem_we,
  output logic                      o_cpu_enable,
  output logic                      o_load_done,
  output logic                      o_error,
  output logic [$clog2(CELDAS):0]   o_word_count
);

  localparam int CW = $clog2(CELDAS) + 1;

  loader_state_t    state, state_nxt;
  logic [NBITS-1:0] load_addr;
  logic [NBITS-1:0] next_addr;
  logic [NBITS-1:0] asm_word;
  logic             word_ready;
  logic             rx_enable;
  logic             is_halt;

  assign rx_enable = (state == ST_RECV) || (state == ST_WRITE);
  assign next_addr = load_addr + NBITS'(WORD_STRIDE);
  assign is_halt   = (o_mem_wdata == HALT_WORD);

  byte_word_assembler #(.W(NBITS)) u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (i_start_load),
    .i_enable     (rx_enable),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .o_word_ready (word_ready),
    .o_word       (asm_word)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and state-decoded port outputs; start pulse overrides all.
  always_comb begin
    state_nxt    = state;
    o_mem_we     = 1'b0;
    o_mem_addr   = i_PC;
    o_cpu_enable = 1'b0;
    o_error      = 1'b0;
    case (state)
      ST_RECV: if (word_ready) state_nxt = ST_WRITE;
      ST_WRITE: begin
        o_mem_we   = 1'b1;
        o_mem_addr = load_addr;
        if (is_halt)                          state_nxt = ST_RUN;
        else if (next_addr >= NBITS'(CELDAS)) state_nxt = ST_OVERFLOW;
        else                                  state_nxt = ST_RECV;
      end
      ST_RUN:      o_cpu_enable = 1'b1;
      ST_OVERFLOW: o_error      = 1'b1;
      default:     ;
    endcase
    if (i_start_load) state_nxt = ST_RECV;
  end

  // Load address, word count, write data and done pulse.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      load_addr    <= '0;
      o_word_count <= '0;
      o_mem_wdata  <= '0;
      o_load_done  <= 1'b0;
    end else begin
      o_load_done <= (state == ST_WRITE) && is_halt && !i_start_load;
      if (word_ready) o_mem_wdata <= asm_word;
      if (i_start_load) begin
        load_addr    <= '0;
        o_word_count <= '0;
      end else if (state == ST_WRITE) begin
        o_word_count <= o_word_count + CW'(1);
        if (!is_halt) load_addr <= next_addr;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader_arbiter.sv
// Self-checking bench for imem_loader_arbiter with a write scoreboard.
module tb_imem_loader_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        i_start_load;
  logic [31:0] i_PC;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_we;
  logic        o_cpu_enable;
  logic        o_load_done;
  logic        o_error;
  logic [6:0]  o_word_count;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  imem_loader_arbiter #(.NBITS(32), .CELDAS(64), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .i_start_load (i_start_load),
    .i_PC         (i_PC),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_we     (o_mem_we),
    .o_cpu_enable (o_cpu_enable),
    .o_load_done  (o_load_done),
    .o_error      (o_error),
    .o_word_count (o_word_count)
  );

  // Scoreboard: every observed write must match the oldest expected one.
  always @(negedge i_clk) begin
    if (o_mem_we === 1'b1) begin
      wr_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%h data=%h", o_mem_addr, o_mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (o_mem_addr !== e.addr || o_mem_wdata !== e.data) begin
          fails++;
          $display("FAIL write got (%h,%h) expected (%h,%h)",
                   o_mem_addr, o_mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic start_pulse();
    i_start_load = 1'b1; tick(); i_start_load = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1; i_rx_data = b; tick(); i_rx_valid = 1'b0;
  endtask

  task automatic send_word_gap(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      tick();
    end
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s pending_writes=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_PC = 32'd8; i_rx_valid = 1'b0; i_rx_data = '0; i_start_load = 1'b0;
    #3;
    tests++;
    if (o_mem_addr !== 32'd8 || o_mem_we !== 1'b0 || o_cpu_enable !== 1'b0) begin
      fails++;
      $display("FAIL reset_port addr=%h we=%b en=%b expected 8,0,0", o_mem_addr, o_mem_we, o_cpu_enable);
    end
    tests++;
    if (o_mem_wdata !== 32'd0 || o_load_done !== 1'b0 || o_error !== 1'b0 || o_word_count !== 7'd0) begin
      fails++;
      $display("FAIL reset_regs wdata=%h done=%b err=%b cnt=%0d expected all 0",
               o_mem_wdata, o_load_done, o_error, o_word_count);
    end
    @(negedge i_clk); i_reset = 1'b1;
    tick();
  endtask

  task automatic test_normal_load();
    logic [31:0] words [4];
    words[0] = 32'h2001_0005; words[1] = 32'h0; words[2] = 32'hAC01_0001; words[3] = 32'hFFFF_FFFF;
    i_PC = 32'h44;
    start_pulse();
    for (int w = 0; w < 4; w++) begin
      expect_wr(32'(w * 4), words[w]);
      for (int i = 3; i >= 0; i--) begin
        send_byte(words[w][i*8 +: 8]);
        if (i != 0 || w != 3) tick();
      end
    end
    tick();
    tests++;
    if (o_load_done !== 1'b1 || o_cpu_enable !== 1'b1 || o_word_count !== 7'd4) begin
      fails++;
      $display("FAIL halt_done done=%b en=%b cnt=%0d expected 1,1,4", o_load_done, o_cpu_enable, o_word_count);
    end
    tests++;
    if (o_mem_addr !== 32'h44) begin
      fails++;
      $display("FAIL run_addr got %h expected 44", o_mem_addr);
    end
    tick();
    i_PC = 32'h48; #1;
    tests++;
    if (o_load_done !== 1'b0 || o_cpu_enable !== 1'b1 || o_mem_addr !== 32'h48) begin
      fails++;
      $display("FAIL run_hold done=%b en=%b addr=%h expected 0,1,48", o_load_done, o_cpu_enable, o_mem_addr);
    end
    send_word_gap(32'h1234_5678);
    check_drained("normal_load");
  endtask

  task automatic test_back_to_back();
    start_pulse();
    tests++;
    if (o_cpu_enable !== 1'b0) begin
      fails++;
      $display("FAIL restart_en got %b expected 0", o_cpu_enable);
    end
    expect_wr(32'd0, 32'h0102_0304);
    expect_wr(32'd4, 32'h0506_0708);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    tick(); tick();
    tests++;
    if (o_word_count !== 7'd2) begin
      fails++;
      $display("FAIL b2b_count got %0d expected 2", o_word_count);
    end
    check_drained("back_to_back");
  endtask

  task automatic test_overflow();
    start_pulse();
    for (int w = 0; w < 16; w++) begin
      expect_wr(32'(w * 4), {4{8'(w)}});
      for (int i = 0; i < 4; i++) send_byte(8'(w));
    end
    tick();
    tests++;
    if (o_error !== 1'b1 || o_word_count !== 7'd16 || o_cpu_enable !== 1'b0) begin
      fails++;
      $display("FAIL overflow err=%b cnt=%0d en=%b expected 1,16,0", o_error, o_word_count, o_cpu_enable);
    end
    for (int i = 0; i < 4; i++) send_byte(8'h55);
    tick(); tick();
    tests++;
    if (o_error !== 1'b1 || o_word_count !== 7'd16) begin
      fails++;
      $display("FAIL overflow_sticky err=%b cnt=%0d expected 1,16", o_error, o_word_count);
    end
    check_drained("overflow");
    start_pulse();
    tests++;
    if (o_error !== 1'b0 || o_word_count !== 7'd0) begin
      fails++;
      $display("FAIL overflow_clear err=%b cnt=%0d expected 0,0", o_error, o_word_count);
    end
  endtask

  task automatic test_restart_mid_word();
    start_pulse();
    send_byte(8'hAA); send_byte(8'hBB);
    start_pulse();
    expect_wr(32'd0, 32'h1122_3344);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    tick(); tick();
    tests++;
    if (o_word_count !== 7'd1) begin
      fails++;
      $display("FAIL restart_count got %0d expected 1", o_word_count);
    end
    check_drained("restart_mid_word");
  endtask

  task automatic test_reset_in_run_and_write();
    start_pulse();
    expect_wr(32'd0, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    tick(); tick();
    tests++;
    if (o_cpu_enable !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_run en=%b expected 1", o_cpu_enable);
    end
    i_PC = 32'h20; i_reset = 1'b0; #1;
    tests++;
    if (o_cpu_enable !== 1'b0 || o_word_count !== 7'd0 || o_mem_addr !== 32'h20) begin
      fails++;
      $display("FAIL reset_run en=%b cnt=%0d addr=%h expected 0,0,20", o_cpu_enable, o_word_count, o_mem_addr);
    end
    @(negedge i_clk); i_reset = 1'b1;
    tick();
    send_word_gap(32'h0BAD_0BAD);
    check_drained("reset_in_run");
    start_pulse();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    tests++;
    if (o_mem_we !== 1'b1) begin
      fails++;
      $display("FAIL write_before_reset we=%b expected 1", o_mem_we);
    end
    i_reset = 1'b0; #1;
    tests++;
    if (o_mem_we !== 1'b0 || o_word_count !== 7'd0 || o_mem_addr !== 32'h20) begin
      fails++;
      $display("FAIL reset_write we=%b cnt=%0d addr=%h expected 0,0,20", o_mem_we, o_word_count, o_mem_addr);
    end
    @(negedge i_clk); i_reset = 1'b1;
    tick(); tick();
    tests++;
    if (o_mem_we !== 1'b0 || o_cpu_enable !== 1'b0 || o_error !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle we=%b en=%b err=%b expected 0,0,0", o_mem_we, o_cpu_enable, o_error);
    end
    check_drained("reset_in_write");
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_back_to_back();
    test_overflow();
    test_restart_mid_word();
    test_reset_in_run_and_write();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader_arbiter.md
# imem_loader_arbiter

Controller for the instruction memory port. It fills program memory from a byte stream supplied by the debug/UART path, with the first byte of each word going to the MSB, and sequences one write per assembled word. It owns the memory address/write port while a load is in progress, then hands the port to instruction fetch (`i_PC`) and enables the CPU once the HALT word has been stored. It sits between the UART receiver / debug unit and the instruction memory, in front of the fetch stage.

## Interface
Parameters:
- `NBITS`, 32, instruction/address width
- `CELDAS`, 64, instruction memory depth in cells; cells are indexed by byte address, and one word is stored per address at multiples of 4
- `HALT_WORD`, 32'hFFFF_FFFF, end-of-program marker

Ports:
- `i_clk`  in  1  system clock; all state changes on its rising edge
- `i_reset`  in  1  asynchronous, active-low reset
- `i_rx_data`  in  8  received byte
- `i_rx_valid`  in  1  one-cycle strobe; `i_rx_data` is valid in that cycle
- `i_start_load`  in  1  one-cycle pulse; begin or restart a program load
- `i_PC`  in  NBITS  fetch address from the PC
- `o_mem_addr`  out  NBITS  memory address: the load address in WRITE, otherwise `i_PC`
- `o_mem_wdata`  out  NBITS  word to write
- `o_mem_we`  out  1  memory write enable
- `o_cpu_enable`  out  1  pipeline/PC advance enable
- `o_load_done`  out  1  one-cycle pulse after the HALT word is written
- `o_error`  out  1  load overflowed memory; sticky
- `o_word_count`  out  $clog2(CELDAS)+1  words written in the current or last load, including HALT

## Operation
- **States:** IDLE, RECV, WRITE, RUN, OVERFLOW.
- **IDLE** (reset state):
  - CPU disabled; port follows `i_PC`; no writes.
  - `i_start_load` -> RECV.
- **Load start.** On entering RECV via `i_start_load`:
  - byte counter = 0, load address = 0;
  - `o_word_count` = 0, `o_error` = 0.
- **RECV:**
  - Each `i_rx_valid` shifts `i_rx_data` into the assembly register (shift left by 8, byte into [7:0]). After four bytes, the first byte occupies [31:24].
  - On the 4th byte: the assembled word is latched into `o_mem_wdata`, the byte counter is cleared, and the next state is WRITE.
- **WRITE** (exactly one cycle):
  - `o_mem_we` = 1, `o_mem_addr` = load address; `o_word_count` increments.
  - Bytes arriving in WRITE are accepted as byte 0 of the next word; no byte is lost.
  - Next state:
    - word == `HALT_WORD` -> RUN (the HALT word itself is stored);
    - else load address += 4, then if the new address >= `CELDAS` -> OVERFLOW, else -> RECV.
- **RUN:**
  - `o_cpu_enable` = 1, `o_mem_addr` = `i_PC`, `o_mem_we` = 0.
  - `i_rx_valid` is ignored.
- **OVERFLOW:**
  - `o_error` = 1, CPU disabled, no writes, `i_rx_valid` ignored.
  - Exits only on `i_start_load` or reset.
- **`i_start_load` priority.** `i_start_load` has priority in every state:
  - next state RECV, counters cleared as above;
  - if asserted during WRITE, that cycle's write still occurs, but the address and count reset;
  - `o_cpu_enable` drops in the cycle after the pulse.
- **Address mux.** The `o_mem_addr` mux is combinational, selected by the registered state. `o_mem_we` is decoded from the registered state (glitch-free).

## Timing
- **Reset values** (asynchronous, immediate on `i_reset` = 0): state IDLE, `o_mem_we` 0, `o_mem_wdata` 0, `o_cpu_enable` 0, `o_load_done` 0, `o_error` 0, `o_word_count` 0, byte counter 0, load address 0. `o_mem_addr` = `i_PC`.
- **Write latency.** 4th-byte strobe in cycle N -> `o_mem_we` = 1 in cycle N+1; memory captures the word at the end of N+1.
- **HALT completion.** For the HALT word: in cycle N+2, `o_cpu_enable` = 1, `o_load_done` = 1 (one cycle only), and `o_mem_addr` = `i_PC`.
- **Overflow.** A non-HALT write at the last legal address (e.g. 60 for CELDAS=64) -> `o_error` = 1 from N+2.
- **Back-to-back bytes.** Strobes on consecutive cycles are supported at full rate, including across WRITE.
- **Reset mid-write.** Reset asserted during WRITE kills `o_mem_we` combinationally-through-state within the reset assertion; no partial write is reported in `o_word_count`.

## Structure
- **Shared package** (`mips_pkg`):
  - state encoding (`loader_state_t`);
  - `HALT_WORD`;
  - `BYTES_PER_WORD` = 4;
  - `WORD_STRIDE` = 4.
- **Sub-module:** `byte_word_assembler`. It holds the shift register and the 2-bit byte counter, and outputs a `word_ready` pulse plus the word. It takes a clear input driven by `i_start_load`.
- **Top-level contents:** FSM, address/count registers, port mux.

## Test plan
- **Reset:** hold `i_reset` = 0 with `i_PC` = 8 -> `o_mem_addr` = 8, `o_mem_we` = 0, `o_cpu_enable` = 0, all other outputs 0.
- **Normal load:** start pulse, then bytes 20 01 00 05 | 00 00 00 00 | AC 01 00 01 | FF FF FF FF -> writes (0, 0x20010005), (4, 0), (8, 0xAC010001), (12, 0xFFFFFFFF). Then `o_load_done` pulses once, `o_cpu_enable` = 1, `o_word_count` = 4, and `o_mem_addr` tracks `i_PC`.
- **Back-to-back bytes:** 8 bytes on consecutive cycles, with the 5th byte landing in WRITE -> second word written correctly at address 4.
- **Overflow:** CELDAS = 64, 16 non-HALT words -> 16 writes at 0..60, then `o_error` = 1 and no 17th write even with further bytes. A subsequent start pulse clears `o_error`.
- **Restart mid-word:** 2 bytes, start pulse, then 11 22 33 44 -> single write (0, 0x11223344).
- **Reset during RUN and during WRITE:** `o_cpu_enable` and `o_mem_we` drop immediately; state returns to IDLE; `o_word_count` = 0.
